// File: rtl/ahb64_apb_bridge.sv
// AHB-Lite slave to APB4 master bridge for the 64-bit system bus.
// Doubleword transfers are split into a lower-word and an upper-word APB access.
module ahb64_apb_bridge #(
    parameter int PAW = 16
) (
    input  logic            HCLK,
    input  logic            HRESET,
    input  logic            HSEL,
    input  logic [31:0]     HADDR,
    input  logic [1:0]      HTRANS,
    input  logic            HWRITE,
    input  logic [2:0]      HSIZE,
    input  logic [63:0]     HWDATA,
    input  logic            HREADY,
    output logic            HREADYOUT,
    output logic [63:0]     HRDATA,
    output logic            HRESP,
    output logic [PAW-1:0]  PADDR,
    output logic            PSEL,
    output logic            PENABLE,
    output logic            PWRITE,
    output logic [31:0]     PWDATA,
    output logic [3:0]      PSTRB,
    input  logic [31:0]     PRDATA,
    input  logic            PREADY,
    input  logic            PSLVERR
);

    typedef enum logic [2:0] {
        IDLE, WDATA, SETUP, ACCESS, DONE, ERR1, ERR2
    } state_t;

    state_t          state, state_d;
    logic [PAW-1:0]  addr_q, addr_d;
    logic            write_q, write_d;
    logic [2:0]      size_q, size_d;
    logic [63:0]     wdata_q, wdata_d;
    logic            upper_q, upper_d;
    logic [31:0]     rlo_q, rlo_d;

    logic            hreadyout_d, hresp_d;
    logic [63:0]     hrdata_d;
    logic [PAW-1:0]  paddr_d;
    logic            psel_d, penable_d, pwrite_d;
    logic [31:0]     pwdata_d;
    logic [3:0]      pstrb_d;

    logic            accept, load_setup, word_sel;
    logic            unused_inputs;

    assign accept        = HSEL & HTRANS[1] & HREADY;
    assign unused_inputs = ^{HADDR, HTRANS};

    function automatic logic [3:0] strobe(input logic [2:0] size, input logic [1:0] a);
        case (size)
            3'd0:    return 4'b0001 << a;
            3'd1:    return 4'b0011 << {a[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    always_comb begin
        state_d     = state;
        addr_d      = addr_q;
        write_d     = write_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        upper_d     = upper_q;
        rlo_d       = rlo_q;
        hrdata_d    = HRDATA;
        paddr_d     = PADDR;
        pwrite_d    = PWRITE;
        pwdata_d    = PWDATA;
        pstrb_d     = PSTRB;
        load_setup  = 1'b0;
        word_sel    = 1'b0;

        case (state)
            IDLE, DONE, ERR2: begin
                state_d = IDLE;
                if (accept) begin
                    addr_d  = HADDR[PAW-1:0];
                    write_d = HWRITE;
                    size_d  = HSIZE;
                    upper_d = 1'b0;
                    if (HSIZE > 3'd3) begin
                        state_d = ERR1;
                    end else if (HWRITE) begin
                        state_d = WDATA;
                    end else begin
                        state_d    = SETUP;
                        load_setup = 1'b1;
                    end
                end
            end
            WDATA: begin
                wdata_d    = HWDATA;
                state_d    = SETUP;
                load_setup = 1'b1;
            end
            SETUP:  state_d = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    if (PSLVERR) begin
                        state_d = ERR1;
                    end else if (size_q == 3'd3 && !upper_q) begin
                        upper_d    = 1'b1;
                        rlo_d      = PRDATA;
                        state_d    = SETUP;
                        load_setup = 1'b1;
                    end else begin
                        state_d  = DONE;
                        hrdata_d = (size_q == 3'd3) ? {PRDATA, rlo_q} : {PRDATA, PRDATA};
                    end
                end
            end
            ERR1:    state_d = ERR2;
            default: state_d = IDLE;
        endcase

        // APB address/data are loaded together with the move into SETUP so they
        // stay frozen through the whole SETUP/ACCESS pair.
        if (load_setup) begin
            word_sel = (size_d == 3'd3) ? upper_d : addr_d[2];
            paddr_d  = {addr_d[PAW-1:3], word_sel, 2'b00};
            pwrite_d = write_d;
            pstrb_d  = write_d ? strobe(size_d, addr_d[1:0]) : '0;
            if (write_d)
                pwdata_d = word_sel ? wdata_d[63:32] : wdata_d[31:0];
        end

        psel_d      = (state_d == SETUP) || (state_d == ACCESS);
        penable_d   = (state_d == ACCESS);
        hreadyout_d = !((state_d == WDATA) || (state_d == SETUP) ||
                        (state_d == ACCESS) || (state_d == ERR1));
        hresp_d     = (state_d == ERR1) || (state_d == ERR2);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            size_q    <= '0;
            wdata_q   <= '0;
            upper_q   <= 1'b0;
            rlo_q     <= '0;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= '0;
            PADDR     <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            PSTRB     <= '0;
        end else begin
            state     <= state_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            upper_q   <= upper_d;
            rlo_q     <= rlo_d;
            HREADYOUT <= hreadyout_d;
            HRESP     <= hresp_d;
            HRDATA    <= hrdata_d;
            PADDR     <= paddr_d;
            PSEL      <= psel_d;
            PENABLE   <= penable_d;
            PWRITE    <= pwrite_d;
            PWDATA    <= pwdata_d;
            PSTRB     <= pstrb_d;
        end
    end

endmodule

// File: tb/tb_ahb64_apb_bridge.sv
// Directed bench for ahb64_apb_bridge: transfer-level model of the expected APB
// accesses and AHB response, an APB slave responder and a per-cycle APB checker.
module tb_ahb64_apb_bridge;
    localparam int PAW = 16;

    logic            HCLK = 1'b0;
    logic            HRESET, HSEL, HWRITE, HREADY;
    logic [31:0]     HADDR;
    logic [1:0]      HTRANS;
    logic [2:0]      HSIZE;
    logic [63:0]     HWDATA;
    logic            HREADYOUT, HRESP;
    logic [63:0]     HRDATA;
    logic [PAW-1:0]  PADDR;
    logic            PSEL, PENABLE, PWRITE;
    logic [31:0]     PWDATA;
    logic [3:0]      PSTRB;
    logic [31:0]     PRDATA;
    logic            PREADY, PSLVERR;

    ahb64_apb_bridge #(.PAW(PAW)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [PAW-1:0] addr;
        logic           w;
        logic [31:0]    wdata;
        logic [3:0]     strb;
    } acc_t;

    typedef struct {
        int          waits;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    acc_t exp_q[$];
    rsp_t rsp_q[$];

    int checks = 0;
    int errors = 0;

    int          m_low, obs_low, rsp_wc;
    logic        m_err, m_w;
    logic [63:0] m_rd, m_wd;
    bit          rsp_completing;
    logic [PAW-1:0] last_paddr;
    logic [3:0]     last_pstrb;
    logic [31:0]    last_pwdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic rsp_t mk(input int waits, input logic [31:0] data, input logic err);
        rsp_t r;
        r.waits = waits;
        r.data  = data;
        r.err   = err;
        return r;
    endfunction

    // Drives an address phase and derives, from the transfer alone, the APB
    // accesses it must produce and the AHB response it must end with.
    task automatic start(input logic [31:0] a, input logic w, input logic [2:0] sz,
                         input logic [63:0] wd, input rsp_t r0, input rsp_t r1);
        acc_t        acc;
        rsp_t        r;
        int          nacc, bytes, ofs, word;
        logic [31:0] base;
        logic [31:0] d [2];
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = w; HSIZE = sz;
        m_w = w; m_wd = wd; m_err = 1'b0; m_low = 0; m_rd = '0;
        d[0] = '0; d[1] = '0;
        if (sz > 3'd3) begin
            m_err = 1'b1;
            m_low = 1;
        end else begin
            nacc  = (sz == 3'd3) ? 2 : 1;
            bytes = 1 << sz;
            ofs   = int'(a[1:0]) & ~(bytes - 1);
            base  = {a[31:3], 3'b000};
            m_low = w ? 1 : 0;
            for (int h = 0; h < nacc; h++) begin
                r         = (h == 0) ? r0 : r1;
                word      = (sz == 3'd3) ? h : int'(a[2]);
                acc.addr  = PAW'(base + 32'(word * 4));
                acc.w     = w;
                acc.wdata = (word == 1) ? wd[63:32] : wd[31:0];
                acc.strb  = !w ? 4'b0000 : (bytes >= 4) ? 4'b1111 : 4'(((1 << bytes) - 1) << ofs);
                exp_q.push_back(acc);
                rsp_q.push_back(r);
                m_low += 2 + r.waits;
                if (r.err) begin
                    m_err = 1'b1;
                    m_low += 1;
                    break;
                end
                d[h] = r.data;
            end
            m_rd = (nacc == 2) ? {d[1], d[0]} : {d[0], d[0]};
        end
    endtask

    // Runs the data phase; returns at the negedge of the completing cycle.
    task automatic complete();
        bit first;
        first   = 1'b1;
        obs_low = 0;
        forever begin
            @(negedge HCLK);
            if (first) begin
                HSEL = 1'b0; HTRANS = 2'b00; HWDATA = m_wd;
                first = 1'b0;
            end
            if (HREADYOUT) break;
            obs_low++;
            chk("hresp_wait", 64'(HRESP), 64'(m_err && obs_low == m_low));
            if (obs_low > 100) begin
                checks++; errors++;
                $display("FAIL timeout: HREADYOUT low for %0d cycles", obs_low);
                break;
            end
        end
        chk("low_cycles", 64'(obs_low), 64'(m_low));
        chk("hresp_done", 64'(HRESP), 64'(m_err));
        if (!m_err && !m_w) chk("hrdata", HRDATA, m_rd);
    endtask

    // APB slave: answers each access from the response queue after its wait count.
    initial begin
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
        rsp_wc = 0; rsp_completing = 1'b0;
        forever begin
            @(posedge HCLK);
            #1;
            if (rsp_completing) begin
                if (rsp_q.size() > 0) rsp_q.delete(0);
                rsp_wc = 0;
                rsp_completing = 1'b0;
            end
            PREADY = 1'b0; PSLVERR = 1'b0;
            if (PSEL && PENABLE) begin
                if (rsp_q.size() == 0) begin
                    PREADY = 1'b1;
                end else if (rsp_wc < rsp_q[0].waits) begin
                    rsp_wc++;
                end else begin
                    PREADY = 1'b1;
                    PRDATA = rsp_q[0].data;
                    PSLVERR = rsp_q[0].err;
                    rsp_completing = 1'b1;
                end
            end
        end
    end

    // APB checker: every selected cycle must match the head expected access.
    initial begin
        forever begin
            @(negedge HCLK);
            if (!HRESET) begin
                if (PENABLE) chk("penable_needs_psel", 64'(PSEL), 64'd1);
                if (PSEL) begin
                    chk("apb_access_expected", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        chk("paddr", 64'(PADDR), 64'(exp_q[0].addr));
                        chk("pwrite", 64'(PWRITE), 64'(exp_q[0].w));
                        chk("pstrb", 64'(PSTRB), 64'(exp_q[0].strb));
                        if (exp_q[0].w) chk("pwdata", 64'(PWDATA), 64'(exp_q[0].wdata));
                        if (PENABLE && PREADY) begin
                            last_paddr  = PADDR;
                            last_pstrb  = PSTRB;
                            last_pwdata = PWDATA;
                            exp_q.delete(0);
                        end
                    end
                end
            end
        end
    end

    initial begin
        HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
        HSIZE = '0; HWDATA = '0; HREADY = 1'b1;
        repeat (3) @(negedge HCLK);
        chk("rst_hreadyout", 64'(HREADYOUT), 64'd1);
        chk("rst_hresp", 64'(HRESP), 64'd0);
        chk("rst_hrdata", HRDATA, 64'd0);
        chk("rst_psel", 64'(PSEL), 64'd0);
        chk("rst_penable", 64'(PENABLE), 64'd0);
        chk("rst_pwrite", 64'(PWRITE), 64'd0);
        chk("rst_paddr", 64'(PADDR), 64'd0);
        chk("rst_pwdata", 64'(PWDATA), 64'd0);
        chk("rst_pstrb", 64'(PSTRB), 64'd0);
        HRESET = 1'b0;

        // Unselected, BUSY, and HREADY-low address phases are ignored
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            HADDR = 32'h4000_0104; HSIZE = 3'd2; HWRITE = 1'b0;
            HSEL   = (i != 0);
            HTRANS = (i == 1) ? 2'b01 : 2'b10;
            HREADY = (i != 2);
            @(negedge HCLK);
            HSEL = 1'b0; HTRANS = 2'b00; HREADY = 1'b1;
            chk("ignored_hreadyout", 64'(HREADYOUT), 64'd1);
            chk("ignored_hresp", 64'(HRESP), 64'd0);
            @(negedge HCLK);
            chk("ignored_hreadyout2", 64'(HREADYOUT), 64'd1);
        end

        // Word read
        @(negedge HCLK);
        start(32'h4000_0104, 1'b0, 3'd2, 64'd0, mk(0, 32'hDEADBEEF, 1'b0), mk(0, 0, 1'b0));
        complete();
        chk("t1_low", 64'(obs_low), 64'd2);
        chk("t1_hrdata", HRDATA, 64'hDEADBEEF_DEADBEEF);
        chk("t1_paddr", 64'(last_paddr), 64'h0104);
        chk("t1_pstrb", 64'(last_pstrb), 64'h0);

        // Byte write to the top lane
        @(negedge HCLK);
        start(32'h4000_0107, 1'b1, 3'd0, 64'h11223344_55667788, mk(0, 0, 1'b0), mk(0, 0, 1'b0));
        complete();
        chk("t2_low", 64'(obs_low), 64'd3);
        chk("t2_paddr", 64'(last_paddr), 64'h0104);
        chk("t2_pstrb", 64'(last_pstrb), 64'h8);
        chk("t2_pwdata", 64'(last_pwdata), 64'h11223344);

        // Doubleword read, two wait states on the lower half
        @(negedge HCLK);
        start(32'h4000_0200, 1'b0, 3'd3, 64'd0, mk(2, 32'hAAAA0000, 1'b0), mk(0, 32'hBBBB1111, 1'b0));
        complete();
        chk("t3_low", 64'(obs_low), 64'd6);
        chk("t3_hrdata", HRDATA, 64'hBBBB1111_AAAA0000);
        chk("t3_paddr", 64'(last_paddr), 64'h0204);

        // Doubleword write, slave error on the lower half
        @(negedge HCLK);
        start(32'h4000_0300, 1'b1, 3'd3, 64'hCAFEF00D_12345678, mk(0, 0, 1'b1), mk(0, 0, 1'b0));
        complete();
        chk("t4_low", 64'(obs_low), 64'd4);
        chk("t4_hresp_err2", 64'(HRESP), 64'd1);
        @(negedge HCLK);
        chk("t4_idle_hreadyout", 64'(HREADYOUT), 64'd1);
        chk("t4_idle_hresp", 64'(HRESP), 64'd0);

        // Halfword write to the upper half of the lower word
        @(negedge HCLK);
        start(32'h4000_00A2, 1'b1, 3'd1, 64'h99887766_55443322, mk(0, 0, 1'b0), mk(0, 0, 1'b0));
        complete();
        chk("t5_pstrb", 64'(last_pstrb), 64'hC);
        chk("t5_pwdata", 64'(last_pwdata), 64'h55443322);
        chk("t5_paddr", 64'(last_paddr), 64'h00A0);

        // Doubleword write, one wait state on the lower half
        @(negedge HCLK);
        start(32'h4000_0308, 1'b1, 3'd3, 64'h01234567_89ABCDEF, mk(1, 0, 1'b0), mk(0, 0, 1'b0));
        complete();
        chk("t6_low", 64'(obs_low), 64'd6);
        chk("t6_paddr", 64'(last_paddr), 64'h030C);
        chk("t6_pwdata", 64'(last_pwdata), 64'h01234567);

        // Back-to-back: read, read in DONE, HSIZE=4 in DONE, read in ERR2
        @(negedge HCLK);
        start(32'h4000_0010, 1'b0, 3'd2, 64'd0, mk(0, 32'h01020304, 1'b0), mk(0, 0, 1'b0));
        complete();
        start(32'h4000_0018, 1'b0, 3'd2, 64'd0, mk(0, 32'h0A0B0C0D, 1'b0), mk(0, 0, 1'b0));
        complete();
        chk("b2b_low", 64'(obs_low), 64'd2);
        chk("b2b_hrdata", HRDATA, 64'h0A0B0C0D_0A0B0C0D);
        start(32'h4000_0020, 1'b0, 3'd4, 64'd0, mk(0, 0, 1'b0), mk(0, 0, 1'b0));
        complete();
        chk("size4_low", 64'(obs_low), 64'd1);
        chk("size4_hresp", 64'(HRESP), 64'd1);
        start(32'h4000_001C, 1'b0, 3'd2, 64'd0, mk(0, 32'h5A5A5A5A, 1'b0), mk(0, 0, 1'b0));
        complete();
        chk("err2_b2b_hrdata", HRDATA, 64'h5A5A5A5A_5A5A5A5A);

        // Reset during ACCESS of a doubleword read
        @(negedge HCLK);
        start(32'h4000_0400, 1'b0, 3'd3, 64'd0, mk(1000, 32'h77777777, 1'b0), mk(0, 0, 1'b0));
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00;
        for (int i = 0; i < 10 && !(PSEL && PENABLE); i++) @(negedge HCLK);
        chk("rst_mid_reached_access", 64'(PSEL && PENABLE), 64'd1);
        HRESET = 1'b1;
        @(negedge HCLK);
        chk("rst_mid_psel", 64'(PSEL), 64'd0);
        chk("rst_mid_penable", 64'(PENABLE), 64'd0);
        chk("rst_mid_hreadyout", 64'(HREADYOUT), 64'd1);
        chk("rst_mid_hrdata", HRDATA, 64'd0);
        exp_q.delete();
        rsp_q.delete();
        rsp_wc = 0;
        rsp_completing = 1'b0;
        HRESET = 1'b0;
        @(negedge HCLK);
        start(32'h4000_0104, 1'b0, 3'd2, 64'd0, mk(0, 32'h13579BDF, 1'b0), mk(0, 0, 1'b0));
        complete();
        chk("post_rst_low", 64'(obs_low), 64'd2);
        chk("post_rst_hrdata", HRDATA, 64'h13579BDF_13579BDF);

        repeat (2) @(negedge HCLK);
        chk("apb_accesses_all_seen", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb64_apb_bridge.md
Name: ahb64_apb_bridge

Overview:
- AHB-Lite slave-to-APB4 master bridge that sits directly downstream of the 2-master/1-slave AHB multiplexer on the 64-bit system bus.
- Converts each 64-bit AHB-Lite transfer into one or two 32-bit APB transfers for low-speed peripherals (UART, GPIO, timers).
- Doubleword transfers (HSIZE=3) are split into a lower-word and an upper-word APB access.

Parameters:
PAW, 16, width of PADDR (peripheral address space), PAW >= 4

Ports:
HCLK  input  1  system clock; all logic on rising edge
HRESET  input  1  synchronous, active-high reset
HSEL  input  1  slave select from address decoder
HADDR  input  32  AHB address
HTRANS  input  2  AHB transfer type; only NONSEQ/SEQ (bit1=1) are acted on
HWRITE  input  1  1=write
HSIZE  input  3  0=byte, 1=half, 2=word, 3=doubleword
HWDATA  input  64  write data, data phase
HREADY  input  1  bus-wide ready (address phase qualifier)
HREADYOUT  output  1  slave ready
HRDATA  output  64  read data
HRESP  output  1  0=OKAY, 1=ERROR
PADDR  output  PAW  APB address
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PWRITE  output  1  APB direction
PWDATA  output  32  APB write data
PSTRB  output  4  APB4 byte strobes
PRDATA  input  32  APB read data
PREADY  input  1  APB ready
PSLVERR  input  1  APB error

Behaviour:
- Reset (HRESET=1 at an edge): state=IDLE; HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0. Reset mid-transfer aborts it with no further APB cycles.
- All outputs are registered. There is no combinational path from PREADY/PSLVERR to HREADYOUT/HRESP.
- Accept condition: HSEL & HTRANS[1] & HREADY, sampled only in states IDLE, DONE and ERR2. In those states the address, HWRITE and HSIZE are captured.
- IDLE/BUSY or unselected transfers: HREADYOUT stays 1, HRESP=0, zero wait.
- States: IDLE, WDATA, SETUP, ACCESS, DONE, ERR1, ERR2.
- IDLE/DONE/ERR2 on accept:
  - HSIZE>3 -> ERR1, no APB access.
  - Write -> WDATA.
  - Read -> SETUP.
  - No accept -> IDLE.
- WDATA: capture HWDATA[63:0] -> SETUP.
- SETUP: PSEL=1, PENABLE=0 -> ACCESS.
- ACCESS: PSEL=1, PENABLE=1. Holds while PREADY=0. On PREADY=1:
  - PSLVERR=1 -> ERR1; the upper half of a doubleword is not issued.
  - First half of a doubleword -> SETUP for the upper half.
  - Otherwise -> DONE.
- DONE: HREADYOUT=1, HRESP=0, HRDATA valid for one cycle.
- ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
- ERR2: HREADYOUT=1, HRESP=1.
- HREADYOUT=0 in WDATA, SETUP, ACCESS and ERR1.
- Address:
  - Word or smaller: PADDR={a[PAW-1:2],2'b00}.
  - Doubleword: lower half uses a[2]=0, upper half uses a[2]=1.
  - Bits a[1:0] appear only via PSTRB.
- Write data:
  - Word or smaller: PWDATA = a[2] ? HWDATA[63:32] : HWDATA[31:0].
  - Doubleword: lower half from [31:0], upper half from [63:32].
- PSTRB on writes: size0 -> 4'b0001<<a[1:0]; size1 -> 4'b0011<<{a[1],1'b0}; size2/3 -> 4'b1111. PSTRB=0 on reads.
- Read data:
  - Word or smaller: HRDATA={PRDATA,PRDATA}, so either lane is correct.
  - Doubleword: HRDATA={upper PRDATA, lower PRDATA}.
  - HRDATA holds its value outside DONE.
- PADDR/PWRITE/PWDATA/PSTRB are stable from SETUP through ACCESS completion. PSEL/PENABLE return to 0 in DONE/ERR1/IDLE.
- Minimum latency, measured in cycles with HREADYOUT=0 after the address phase:
  - Word read: 2.
  - Word write: 3.
  - Doubleword read: 4.
  - Doubleword write: 5.
  - Add 1 per PREADY=0 cycle.
- Back-to-back: an accept in DONE goes directly to WDATA/SETUP with no IDLE bubble.

Test Plan:
- Word read at 0x4000_0104, PREADY=1, PRDATA=0xDEADBEEF -> SETUP then ACCESS with PADDR=0x0104, PSTRB=0; DONE 3 cycles after the address phase with HRDATA=0xDEADBEEF_DEADBEEF, HRESP=0.
- Byte write HADDR=0x...0107, HWDATA=0x11223344_55667788 -> PADDR=0x0104, PSTRB=4'b1000, PWDATA=0x11223344; HREADYOUT low 3 cycles.
- Doubleword read at 0x...0200 with PREADY held 0 for 2 cycles on the first half, PRDATA=0xAAAA0000 then 0xBBBB1111 -> two APB accesses at 0x0200 and 0x0204; HRDATA=0xBBBB1111_AAAA0000; HREADYOUT low 6 cycles.
- Doubleword write with PSLVERR=1 on the first half -> no access at +4; ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); then IDLE.
- Back-to-back reads accepted in DONE, plus an HSIZE=4 transfer -> the second read starts SETUP on the next cycle; HSIZE=4 gives a two-cycle ERROR with PSEL never asserted.
- HRESET=1 during ACCESS of a doubleword -> next cycle PSEL=0, PENABLE=0, HREADYOUT=1, HRDATA=0; the following word read completes normally.
